// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped IO responder: register offsets
// within the 3-register window and STATUS bit positions.
package io_pkg;

    localparam int IO_DATA_OFS   = 0;
    localparam int IO_STATUS_OFS = 1;
    localparam int IO_COUNT_OFS  = 2;

    localparam int STAT_RX_NONEMPTY_BIT = 0;
    localparam int STAT_TX_NONFULL_BIT  = 1;
    localparam int STAT_DROP_BIT        = 3;
    localparam int STAT_UNDERRUN_BIT    = 4;

    typedef enum logic [1:0] {
        IO_DATA   = 2'(IO_DATA_OFS),
        IO_STATUS = 2'(IO_STATUS_OFS),
        IO_COUNT  = 2'(IO_COUNT_OFS)
    } io_reg_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head output. Push is ignored
// when full and pop is ignored when empty; contents survive reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap without explicit logic.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_io_responder.sv
// Device side of the CPU's IO window: DATA/STATUS/COUNT registers in front of
// an RX FIFO (external producer -> CPU loads) and a TX FIFO (CPU stores -> consumer).
module mmio_io_responder
    import io_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_IO    = 252,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wren,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] ADDR_LO = DATA_WIDTH'(ADDR_IO);

    logic [DATA_WIDTH-1:0] w_ofs;
    logic                  w_sel;
    io_reg_e               w_reg;
    logic                  w_rd_data;
    logic                  w_wr_data;
    logic                  w_wr_status;
    logic [DATA_WIDTH-1:0] w_rx_dout;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic [CW-1:0]         w_rx_count;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic [CW-1:0]         w_tx_count;
    logic [7:0]            w_status;
    logic [7:0]            w_count;
    logic                  r_underrun;
    logic                  r_drop;

    // Unsigned offset; addresses below the base wrap high and fail the range test.
    assign w_ofs       = address - ADDR_LO;
    assign w_sel       = (w_ofs < DATA_WIDTH'(3));
    assign w_reg       = io_reg_e'(w_ofs[1:0]);
    assign w_rd_data   = w_sel && rden && (w_reg == IO_DATA);
    assign w_wr_data   = w_sel && wren && (w_reg == IO_DATA);
    assign w_wr_status = w_sel && wren && (w_reg == IO_STATUS);

    assign in_ready  = reset && !w_rx_full;
    assign out_valid = !w_tx_empty;

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid && in_ready),
        .pop   (w_rd_data),
        .din   (in_data),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_wr_data),
        .pop   (out_valid && out_ready),
        .din   (wdata),
        .dout  (out_data),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    assign w_status = {3'b000, r_underrun, r_drop, 1'b0, !w_tx_full, !w_rx_empty};
    assign w_count  = {4'(w_tx_count), 4'(w_rx_count)};

    always_comb begin
        rdata = '0;
        if (w_sel) begin
            case (w_reg)
                IO_DATA:   rdata = w_rx_empty ? '0 : w_rx_dout;
                IO_STATUS: rdata = DATA_WIDTH'(w_status);
                IO_COUNT:  rdata = DATA_WIDTH'(w_count);
                default:   rdata = '0;
            endcase
        end
    end

    // Set and clear come from different offsets, so they never collide.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_underrun <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            if (w_rd_data && w_rx_empty) begin
                r_underrun <= 1'b1;
            end else if (w_wr_status && wdata[STAT_UNDERRUN_BIT]) begin
                r_underrun <= 1'b0;
            end
            if (w_wr_data && w_tx_full) begin
                r_drop <= 1'b1;
            end else if (w_wr_status && wdata[STAT_DROP_BIT]) begin
                r_drop <= 1'b0;
            end
        end
    end

endmodule
